ps2_tx_bank: RTL and testbench

//  Parametrised bank of NCH independent PS/2 device-side transmitters (keyboard, mouse, extra pads).

---
 rtl/ps2_tx_bank_if.sv | 24 ++
 rtl/ps2_tx_bank.sv | 161 ++++++++++++++++
 tb/tb_ps2_tx_bank.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_tx_bank_if.sv
// Host-side bus of the PS/2 transmitter bank. Carries the per-channel write strobes, write data
// and inhibit inputs, and returns the FIFO status and the PS/2 line outputs.
interface ps2_tx_bank_if #(
  parameter int NCH = 2
) ();
  logic [NCH-1:0]   wr;
  logic [8*NCH-1:0] din;
  logic [NCH-1:0]   inhibit;
  logic [NCH-1:0]   full;
  logic [NCH-1:0]   overflow;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   ps2_clk;
  logic [NCH-1:0]   ps2_data;

  modport master (
    output wr, din, inhibit,
    input  full, overflow, busy, ps2_clk, ps2_data
  );

  modport slave (
    input  wr, din, inhibit,
    output full, overflow, busy, ps2_clk, ps2_data
  );
endinterface

// File: rtl/ps2_tx_bank.sv
// Bank of NCH independent PS/2 device-side transmitters. Each channel has its own byte FIFO
// and frame FSM; all channels step on one shared, free-running PS/2 clock divider.
module ps2_tx_bank #(
  parameter int NCH    = 2,
  parameter int DEPTH  = 8,
  parameter int PS2DIV = 100
) (
  input  logic         clk_sys,
  input  logic         reset,
  ps2_tx_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PS2DIV);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [CW-1:0] DIV_LAST = CW'(PS2DIV - 1);

  // State names follow the bit currently on the data line.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_D0    = 4'd2,
    ST_D1    = 4'd3,
    ST_D2    = 4'd4,
    ST_D3    = 4'd5,
    ST_D4    = 4'd6,
    ST_D5    = 4'd7,
    ST_D6    = 4'd8,
    ST_D7    = 4'd9,
    ST_PAR   = 4'd10,
    ST_STOP  = 4'd11
  } state_t;

  logic [CW-1:0] div_cnt;
  logic          clk_ps2;
  logic          tick;

  // tick marks the system cycle whose closing edge raises clk_ps2.
  assign tick = (div_cnt == DIV_LAST) && !clk_ps2;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt <= '0;
      clk_ps2 <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      clk_ps2 <= ~clk_ps2;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        fifo_full, fifo_empty, push, pop, ovf_q;
    logic        wr_i, inh_i;
    logic [7:0]  din_i, head;
    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic        data_q, data_d;

    assign wr_i  = bus.wr[i];
    assign inh_i = bus.inhibit[i];
    assign din_i = bus.din[8*i +: 8];
    assign head  = mem[rptr[AW-1:0]];

    // The extra pointer bit tells a full FIFO from an empty one.
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // A completing frame frees its slot in the same cycle, so a write to a full FIFO still lands.
    assign pop  = tick && (state_q == ST_STOP);
    assign push = wr_i && (!fifo_full || pop);

    // NOTE: the byte storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_sys) begin
      if (push) mem[wptr[AW-1:0]] <= din_i;
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        wptr  <= '0;
        rptr  <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (push) wptr <= wptr + PTR_ONE;
        if (pop)  rptr <= rptr + PTR_ONE;
        if (wr_i && fifo_full && !pop) ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        shift_q  <= '0;
        parity_q <= 1'b0;
        data_q   <= 1'b1;
      end else begin
        state_q  <= state_d;
        shift_q  <= shift_d;
        parity_q <= parity_d;
        data_q   <= data_d;
      end
    end

    always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d  = state_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      data_d   = data_q;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (!fifo_empty && !inh_i) begin
              shift_d  = head;
              parity_d = 1'b1;
              data_d   = 1'b0;
              state_d  = ST_START;
            end
          end
          ST_START, ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_D6, ST_D7: begin
            // Aborted bytes stay at the FIFO head and restart from their start bit.
            if (inh_i) begin
              data_d  = 1'b1;
              state_d = ST_IDLE;
            end else if (state_q == ST_D7) begin
              data_d  = parity_q;
              state_d = ST_PAR;
            end else begin
              data_d   = shift_q[0];
              shift_d  = {1'b0, shift_q[7:1]};
              parity_d = parity_q ^ shift_q[0];
              state_d  = state_t'(state_q + 4'd1);
            end
          end
          ST_PAR: begin
            data_d  = 1'b1;
            state_d = ST_STOP;
          end
          ST_STOP: begin
            data_d  = 1'b1;
            state_d = ST_IDLE;
          end
          default: begin
            data_d  = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
    end

    assign bus.full[i]     = fifo_full;
    assign bus.overflow[i] = ovf_q;
    assign bus.busy[i]     = (state_q != ST_IDLE);
    assign bus.ps2_clk[i]  = clk_ps2 | (state_q == ST_IDLE);
    assign bus.ps2_data[i] = data_q;
  end
endmodule

// File: tb/tb_ps2_tx_bank.sv
// Self-checking bench for ps2_tx_bank: a per-channel line monitor decodes PS/2 frames on the
// falling clock edge and compares them against a queue of bytes the FIFO is expected to send.
module tb_ps2_tx_bank;
  localparam int NCH    = 2;
  localparam int DEPTH  = 8;
  localparam int PS2DIV = 4;
  localparam int FRAME  = 12 * 2 * PS2DIV;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  ps2_tx_bank_if #(.NCH(NCH)) bus ();

  ps2_tx_bank #(.NCH(NCH), .DEPTH(DEPTH), .PS2DIV(PS2DIV)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0]  exp_q   [NCH][$];
  int          start_q [NCH][$];
  int          rx_cnt  [NCH];
  logic [10:0] last_bits [NCH];

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Line monitor: bits are taken on each falling ps2_clk edge of a frame; a frame that ends
  // with all 11 bits is scored, a shorter one (abort or reset) is discarded.
  for (genvar c = 0; c < NCH; c++) begin : g_mon
    initial begin
      logic [10:0] bits;
      logic [10:0] want;
      logic [7:0]  e;
      int          n;
      logic        pclk, pbusy;
      bits = '0; n = 0; pclk = 1'b1; pbusy = 1'b0;
      forever begin
        @(negedge clk_sys);
        if (!pbusy && bus.busy[c] === 1'b1) start_q[c].push_back(cyc);
        if (pclk === 1'b1 && bus.ps2_clk[c] === 1'b0 && bus.busy[c] === 1'b1 && n < 11) begin
          bits[n] = bus.ps2_data[c];
          n++;
        end
        if (pbusy && bus.busy[c] !== 1'b1) begin
          if (n == 11) begin
            vectors++;
            last_bits[c] = bits;
            rx_cnt[c]++;
            if (exp_q[c].size() == 0) begin
              miscompares++;
              $display("FAIL frame ch%0d: got %b, expected no frame", c, bits);
            end else begin
              e    = exp_q[c].pop_front();
              want = {1'b1, ~^e, e, 1'b0};
              if (bits !== want) begin
                miscompares++;
                $display("FAIL frame ch%0d: got %b, expected %b", c, bits, want);
              end
            end
          end
          n = 0;
        end
        pclk  = bus.ps2_clk[c];
        pbusy = (bus.busy[c] === 1'b1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk_sys);
    reset       = 1'b1;
    bus.wr      = '0;
    bus.din     = '0;
    bus.inhibit = '0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      start_q[c].delete();
    end
  endtask

  // One write cycle; the scoreboard takes a byte unless the FIFO model is full and no pop coincides.
  task automatic write_cycle(input logic [NCH-1:0] mask, input logic [8*NCH-1:0] data,
                             input bit pop_now);
    @(negedge clk_sys);
    for (int c = 0; c < NCH; c++)
      if (mask[c] && (exp_q[c].size() < DEPTH || pop_now)) exp_q[c].push_back(data[8*c +: 8]);
    bus.wr  = mask;
    bus.din = data;
    @(negedge clk_sys);
    bus.wr = '0;
  endtask

  task automatic wait_busy(input int ch, input logic level);
    int n = 0;
    while (bus.busy[ch] !== level && n < 4 * FRAME) begin
      @(negedge clk_sys);
      n++;
    end
    if (bus.busy[ch] !== level) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_wait ch%0d: busy=%b, required %b within %0d cycles", ch, bus.busy[ch], level, n);
    end
  endtask

  task automatic wait_clk_rises(input int ch, input int count);
    int   seen = 0;
    int   n    = 0;
    logic p;
    p = bus.ps2_clk[ch];
    while (seen < count && n < 4 * FRAME) begin
      @(negedge clk_sys);
      n++;
      if (p === 1'b0 && bus.ps2_clk[ch] === 1'b1) seen++;
      p = bus.ps2_clk[ch];
    end
    if (seen < count) begin
      vectors++;
      miscompares++;
      $display("FAIL clk_rises ch%0d: saw %0d, required %0d", ch, seen, count);
    end
  endtask

  task automatic wait_idle(input int ch, input int budget);
    int n = 0;
    while ((exp_q[ch].size() != 0 || bus.busy[ch] !== 1'b0) && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    vectors++;
    if (exp_q[ch].size() != 0 || bus.busy[ch] !== 1'b0) begin
      miscompares++;
      $display("FAIL drain ch%0d: %0d frames outstanding, busy=%b, required 0 and 0",
               ch, exp_q[ch].size(), bus.busy[ch]);
    end
    @(negedge clk_sys);
  endtask

  task automatic check_quiet(input int ch, input int cycles, input string what);
    int busy_cyc = 0;
    int clk_low  = 0;
    repeat (cycles) begin
      @(negedge clk_sys);
      if (bus.busy[ch] !== 1'b0)    busy_cyc++;
      if (bus.ps2_clk[ch] !== 1'b1) clk_low++;
    end
    vectors++;
    if (busy_cyc != 0 || clk_low != 0) begin
      miscompares++;
      $display("FAIL %s ch%0d: busy %0d cycles, ps2_clk low %0d cycles, required 0 and 0",
               what, ch, busy_cyc, clk_low);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    vectors += 5;
    if (bus.full !== '0)     begin miscompares++; $display("FAIL reset_full: got %b, required 00", bus.full); end
    if (bus.overflow !== '0) begin miscompares++; $display("FAIL reset_overflow: got %b, required 00", bus.overflow); end
    if (bus.busy !== '0)     begin miscompares++; $display("FAIL reset_busy: got %b, required 00", bus.busy); end
    if (bus.ps2_data !== '1) begin miscompares++; $display("FAIL reset_data: got %b, required 11", bus.ps2_data); end
    if (bus.ps2_clk !== '1)  begin miscompares++; $display("FAIL reset_clk: got %b, required 11", bus.ps2_clk); end
    reset = 1'b0;
    check_quiet(0, 2 * FRAME, "idle_after_reset");
  endtask

  task automatic test_single_frame();
    int rx0;
    do_reset();
    rx0 = rx_cnt[0];
    write_cycle(2'b01, {8'h00, 8'h1C}, 1'b0);
    wait_idle(0, 3 * FRAME);
    vectors += 2;
    if (rx_cnt[0] - rx0 != 1) begin
      miscompares++;
      $display("FAIL single_count: got %0d frames, required 1", rx_cnt[0] - rx0);
    end
    if (last_bits[0] !== 11'b10000111000) begin
      miscompares++;
      $display("FAIL single_bits: got %b, required 10000111000", last_bits[0]);
    end
    check_quiet(0, FRAME, "idle_after_frame");
  endtask

  task automatic test_two_channels();
    do_reset();
    write_cycle(2'b11, {8'h55, 8'hAA}, 1'b0);
    wait_idle(0, 3 * FRAME);
    wait_idle(1, 3 * FRAME);
    vectors++;
    if (start_q[0].size() != 1 || start_q[1].size() != 1 || start_q[0][0] != start_q[1][0]) begin
      miscompares++;
      $display("FAIL two_ch_start: ch0 %0d starts, ch1 %0d starts, required 1 each on the same cycle",
               start_q[0].size(), start_q[1].size());
    end
  endtask

  task automatic test_full_pop();
    int rx0;
    do_reset();
    rx0 = rx_cnt[0];
    for (int i = 0; i < DEPTH; i++) write_cycle(2'b01, {8'h00, 8'(8'hC0 + i)}, 1'b0);
    wait_busy(0, 1'b0);
    write_cycle(2'b01, {8'h00, 8'hC8}, 1'b0);
    vectors++;
    if (bus.full[0] !== 1'b1) begin miscompares++; $display("FAIL refill_full: got %b, required 1", bus.full[0]); end
    // Place the next write on the very cycle the current frame pops its byte.
    wait_busy(0, 1'b1);
    wait_clk_rises(0, 10);
    repeat (2 * PS2DIV - 2) @(negedge clk_sys);
    write_cycle(2'b01, {8'h00, 8'hC9}, 1'b1);
    vectors += 2;
    if (bus.full[0] !== 1'b1)     begin miscompares++; $display("FAIL pop_write_full: got %b, required 1", bus.full[0]); end
    if (bus.overflow[0] !== 1'b0) begin miscompares++; $display("FAIL pop_write_ovf: got %b, required 0", bus.overflow[0]); end
    wait_idle(0, 12 * FRAME);
    vectors++;
    if (rx_cnt[0] - rx0 != DEPTH + 2) begin
      miscompares++;
      $display("FAIL pop_write_count: got %0d frames, required %0d", rx_cnt[0] - rx0, DEPTH + 2);
    end
  endtask

  task automatic test_overflow_back_to_back();
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      write_cycle(2'b01, {8'h00, 8'(i)}, 1'b0);
      if (i == DEPTH - 1) begin
        vectors++;
        if (bus.full[0] !== 1'b0) begin miscompares++; $display("FAIL full_early: got %b, required 0", bus.full[0]); end
      end
      if (i == DEPTH) begin
        vectors += 2;
        if (bus.full[0] !== 1'b1)     begin miscompares++; $display("FAIL full_at_depth: got %b, required 1", bus.full[0]); end
        if (bus.overflow[0] !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b, required 0", bus.overflow[0]); end
      end
    end
    vectors += 2;
    if (bus.overflow !== 2'b01) begin miscompares++; $display("FAIL ovf_set: got %b, required 01", bus.overflow); end
    if (bus.full !== 2'b01)     begin miscompares++; $display("FAIL full_after_drop: got %b, required 01", bus.full); end
    wait_idle(0, 10 * FRAME);
    vectors += 2;
    if (bus.overflow[0] !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b, required 1", bus.overflow[0]); end
    if (start_q[0].size() != DEPTH) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d frames, required %0d", start_q[0].size(), DEPTH);
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        vectors++;
        if (start_q[0][k] - start_q[0][k-1] != FRAME) begin
          miscompares++;
          $display("FAIL b2b_gap%0d: got %0d cycles, required %0d", k, start_q[0][k] - start_q[0][k-1], FRAME);
        end
      end
    end
  endtask

  task automatic test_inhibit_abort();
    int rx0;
    do_reset();
    rx0 = rx_cnt[0];
    write_cycle(2'b01, {8'h00, 8'h12}, 1'b0);
    wait_busy(0, 1'b1);
    wait_clk_rises(0, 4);
    bus.inhibit = 2'b01;
    repeat (2 * PS2DIV + 1) @(negedge clk_sys);
    vectors += 2;
    if (bus.busy[0] !== 1'b0)     begin miscompares++; $display("FAIL abort_busy: got %b, required 0", bus.busy[0]); end
    if (bus.ps2_data[0] !== 1'b1) begin miscompares++; $display("FAIL abort_data: got %b, required 1", bus.ps2_data[0]); end
    check_quiet(0, 2 * FRAME, "inhibit_idle");
    bus.inhibit = 2'b00;
    wait_idle(0, 3 * FRAME);
    check_quiet(0, 2 * FRAME, "after_resend");
    vectors++;
    if (rx_cnt[0] - rx0 != 1) begin
      miscompares++;
      $display("FAIL resend_count: got %0d frames, required 1", rx_cnt[0] - rx0);
    end
  endtask

  task automatic test_inhibit_late();
    int rx0;
    do_reset();
    rx0 = rx_cnt[0];
    write_cycle(2'b01, {8'h00, 8'h33}, 1'b0);
    write_cycle(2'b01, {8'h00, 8'h44}, 1'b0);
    wait_busy(0, 1'b1);
    wait_clk_rises(0, 9);
    bus.inhibit = 2'b01;
    wait_busy(0, 1'b0);
    @(negedge clk_sys);
    vectors++;
    if (rx_cnt[0] - rx0 != 1) begin
      miscompares++;
      $display("FAIL late_complete: got %0d frames, required 1", rx_cnt[0] - rx0);
    end
    check_quiet(0, 2 * FRAME, "late_hold");
    bus.inhibit = 2'b00;
    wait_idle(0, 3 * FRAME);
    vectors++;
    if (rx_cnt[0] - rx0 != 2) begin
      miscompares++;
      $display("FAIL late_release: got %0d frames, required 2", rx_cnt[0] - rx0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rx0;
    do_reset();
    write_cycle(2'b01, {8'h00, 8'hA1}, 1'b0);
    write_cycle(2'b01, {8'h00, 8'hB2}, 1'b0);
    write_cycle(2'b01, {8'h00, 8'hC3}, 1'b0);
    wait_busy(0, 1'b1);
    wait_clk_rises(0, 3);
    reset = 1'b1;
    @(negedge clk_sys);
    vectors += 4;
    if (bus.ps2_data[0] !== 1'b1) begin miscompares++; $display("FAIL rst_mid_data: got %b, required 1", bus.ps2_data[0]); end
    if (bus.ps2_clk[0] !== 1'b1)  begin miscompares++; $display("FAIL rst_mid_clk: got %b, required 1", bus.ps2_clk[0]); end
    if (bus.busy[0] !== 1'b0)     begin miscompares++; $display("FAIL rst_mid_busy: got %b, required 0", bus.busy[0]); end
    if (bus.full[0] !== 1'b0)     begin miscompares++; $display("FAIL rst_mid_full: got %b, required 0", bus.full[0]); end
    reset = 1'b0;
    exp_q[0].delete();
    rx0 = rx_cnt[0];
    check_quiet(0, 3 * FRAME, "after_mid_reset");
    vectors++;
    if (rx_cnt[0] != rx0) begin
      miscompares++;
      $display("FAIL rst_mid_frames: got %0d frames, required 0", rx_cnt[0] - rx0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr      = '0;
    bus.din     = '0;
    bus.inhibit = '0;
    test_reset();
    test_single_frame();
    test_two_channels();
    test_full_pop();
    test_overflow_back_to_back();
    test_inhibit_abort();
    test_inhibit_late();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
